// File: rtl/regfile_sb.sv
// regfile_sb: register file with scoreboard busy bits and an optional debug port (enabled by REGFILE_SB_DBG_EN)
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int SP_IDX = 2,
  parameter logic [XLEN-1:0] SP_INIT = 'h2000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(NREG)-1:0] rs1_addr_i,
  input  logic [$clog2(NREG)-1:0] rs2_addr_i,
  output logic [XLEN-1:0]         rs1_data_o,
  output logic [XLEN-1:0]         rs2_data_o,
  output logic                    rs1_busy_o,
  output logic                    rs2_busy_o,
  input  logic                    wr_en,
  input  logic [$clog2(NREG)-1:0] rd_addr_i,
  input  logic [XLEN-1:0]         rd_data_i,
  input  logic                    iss_en_i,
  input  logic [$clog2(NREG)-1:0] iss_addr_i,
  input  logic                    dbg_req_i,
  input  logic                    dbg_we_i,
  input  logic [$clog2(NREG)-1:0] dbg_addr_i,
  input  logic [XLEN-1:0]         dbg_wdata_i,
  output logic                    dbg_ack_o,
  output logic [XLEN-1:0]         dbg_rdata_o
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic            w_dbg_wr;

  // x0 and the reset window read as zero; a same-cycle writeback is forwarded
  assign rs1_data_o = (!rst || rs1_addr_i == '0) ? '0 :
                      (wr_en && rd_addr_i == rs1_addr_i) ? rd_data_i : r_regs[rs1_addr_i];
  assign rs2_data_o = (!rst || rs2_addr_i == '0) ? '0 :
                      (wr_en && rd_addr_i == rs2_addr_i) ? rd_data_i : r_regs[rs2_addr_i];

  // busy[0] is never set, so x0 reports not-busy without a special case
  assign rs1_busy_o = r_busy[rs1_addr_i] && !(wr_en && rd_addr_i == rs1_addr_i);
  assign rs2_busy_o = r_busy[rs2_addr_i] && !(wr_en && rd_addr_i == rs2_addr_i);

  assign w_set = iss_en_i ? (NREG'(1) << iss_addr_i) : '0;
  assign w_clr = wr_en ? (NREG'(1) << rd_addr_i) : '0;

  // register storage: writeback first, debug writes only happen when writeback is idle
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < NREG; i++) r_regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
    else if (wr_en && rd_addr_i != '0)
      r_regs[rd_addr_i] <= rd_data_i;
    else if (w_dbg_wr)
      r_regs[dbg_addr_i] <= dbg_wdata_i;

  // scoreboard: issue sets, writeback clears, set wins on collision, bit 0 pinned low
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_busy <= '0;
    else      r_busy <= ((r_busy & ~w_clr) | w_set) & ~NREG'(1);

`ifdef REGFILE_SB_DBG_EN
  localparam logic [1:0] S_IDLE = 2'd0, S_ACK = 2'd1, S_REL = 2'd2;
  logic [1:0]      r_state;
  logic [XLEN-1:0] r_rdata;
  logic            w_dbg_go;

  assign w_dbg_go    = r_state == S_IDLE && dbg_req_i && !wr_en;
  assign w_dbg_wr    = w_dbg_go && dbg_we_i && dbg_addr_i != '0;
  assign dbg_ack_o   = r_state == S_ACK;
  assign dbg_rdata_o = r_rdata;

  // debug handshake: access in IDLE, one-cycle ack, wait for request to drop
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= S_IDLE;
      r_rdata <= '0;
    end else begin
      r_state <= (r_state == S_IDLE) ? (w_dbg_go ? S_ACK : S_IDLE) :
                 (r_state == S_ACK) ? S_REL : (dbg_req_i ? S_REL : S_IDLE);
      if (w_dbg_go && !w_dbg_wr) r_rdata <= r_regs[dbg_addr_i];
    end
`else
  logic w_unused;

  assign w_unused    = ^{dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, AW[0]};
  assign w_dbg_wr    = 1'b0;
  assign dbg_ack_o   = 1'b0;
  assign dbg_rdata_o = '0;
`endif
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: vector table plus scoreboard queue for regfile_sb, with debug sequences per build
module tb_regfile_sb;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] rs1_addr_i = '0, rs2_addr_i = '0, rd_addr_i = '0, iss_addr_i = '0, dbg_addr_i = '0;
  logic [31:0]   rs1_data_o, rs2_data_o, dbg_rdata_o;
  logic          rs1_busy_o, rs2_busy_o, dbg_ack_o;
  logic          wr_en = 1'b0, iss_en_i = 1'b0, dbg_req_i = 1'b0, dbg_we_i = 1'b0;
  logic [31:0]   rd_data_i = '0, dbg_wdata_i = '0;

  typedef struct {
    logic          wr;
    logic [AW-1:0] rd;
    logic [31:0]   wd;
    logic          iss;
    logic [AW-1:0] ia;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [31:0]   e1;
    logic [31:0]   e2;
    logic          eb1;
    logic          eb2;
  } vec_t;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
  } exp_t;

  exp_t sbq[$];
  vec_t tv[13];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst(rst),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
    .wr_en(wr_en), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
    .iss_en_i(iss_en_i), .iss_addr_i(iss_addr_i),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int n);
    exp_t e;
    exp_t g;
    @(negedge clk);
    wr_en = v.wr; rd_addr_i = v.rd; rd_data_i = v.wd;
    iss_en_i = v.iss; iss_addr_i = v.ia;
    rs1_addr_i = v.a1; rs2_addr_i = v.a2;
    e.d1 = v.e1; e.d2 = v.e2; e.b1 = v.eb1; e.b2 = v.eb2;
    sbq.push_back(e);
    #1;
    g = sbq.pop_front();
    chk($sformatf("vec%0d_rs1_data", n), rs1_data_o, g.d1);
    chk($sformatf("vec%0d_rs2_data", n), rs2_data_o, g.d2);
    chk($sformatf("vec%0d_rs1_busy", n), rs1_busy_o, g.b1);
    chk($sformatf("vec%0d_rs2_busy", n), rs2_busy_o, g.b2);
  endtask

  task automatic idle_inputs();
    wr_en = 0; iss_en_i = 0; rd_addr_i = '0; rd_data_i = '0; iss_addr_i = '0;
  endtask

  initial begin
    //         wr rd  wd            iss ia a1 a2  e1            e2            b1 b2
    tv[0]  = '{0, 0,  0,            0,  0, 2, 5,  32'h2000,     0,            0, 0};
    tv[1]  = '{1, 7,  32'hDEADBEEF, 0,  0, 7, 0,  32'hDEADBEEF, 0,            0, 0};
    tv[2]  = '{0, 0,  0,            0,  0, 7, 2,  32'hDEADBEEF, 32'h2000,     0, 0};
    tv[3]  = '{0, 0,  0,            1,  9, 0, 9,  0,            0,            0, 0};
    tv[4]  = '{0, 0,  0,            0,  0, 9, 9,  0,            0,            1, 1};
    tv[5]  = '{1, 9,  32'h55,       1,  9, 0, 9,  0,            32'h55,       0, 0};
    tv[6]  = '{0, 0,  0,            0,  0, 9, 9,  32'h55,       32'h55,       1, 1};
    tv[7]  = '{1, 9,  32'h66,       0,  0, 9, 0,  32'h66,       0,            0, 0};
    tv[8]  = '{0, 0,  0,            0,  0, 9, 9,  32'h66,       32'h66,       0, 0};
    tv[9]  = '{1, 0,  32'hFFFFFFFF, 1,  0, 0, 2,  0,            32'h2000,     0, 0};
    tv[10] = '{0, 0,  0,            0,  0, 0, 0,  0,            0,            0, 0};
    tv[11] = '{1, 2,  32'h12345678, 0,  0, 5, 2,  0,            32'h12345678, 0, 0};
    tv[12] = '{0, 0,  0,            0,  0, 2, 7,  32'h12345678, 32'hDEADBEEF, 0, 0};

    rs1_addr_i = 2;
    #1;
    chk("reset_rs1_data", rs1_data_o, 0);
    chk("reset_dbg_ack", dbg_ack_o, 0);
    chk("reset_dbg_rdata", dbg_rdata_o, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int n = 0; n < 13; n++) apply(tv[n], n);

`ifdef REGFILE_SB_DBG_EN
    @(negedge clk);
    idle_inputs();
    iss_en_i = 1; iss_addr_i = 3;
    @(negedge clk);
    iss_en_i = 0;
    wr_en = 1; rd_addr_i = 10; rd_data_i = 32'hAAAA;
    dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 3; dbg_wdata_i = 32'h1234;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("dbg_blocked%0d_ack", k), dbg_ack_o, 0);
      @(negedge clk);
    end
    wr_en = 0;
    #1 chk("dbg_wr_pre_ack", dbg_ack_o, 0);
    @(negedge clk);
    rs1_addr_i = 3;
    #1;
    chk("dbg_wr_ack", dbg_ack_o, 1);
    chk("dbg_wr_x3", rs1_data_o, 32'h1234);
    chk("dbg_wr_busy_kept", rs1_busy_o, 1);
    @(negedge clk);
    dbg_req_i = 0;
    #1 chk("dbg_wr_ack_one_cycle", dbg_ack_o, 0);
    @(negedge clk);
    dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 3;
    #1 chk("dbg_rd_pre_ack", dbg_ack_o, 0);
    @(negedge clk);
    dbg_req_i = 0;
    #1;
    chk("dbg_rd_ack", dbg_ack_o, 1);
    chk("dbg_rd_data", dbg_rdata_o, 32'h1234);
    @(negedge clk);
    #1;
    chk("dbg_rd_ack_drop", dbg_ack_o, 0);
    chk("dbg_rd_data_hold", dbg_rdata_o, 32'h1234);
    @(negedge clk);
    dbg_req_i = 1; dbg_addr_i = 2; rs1_addr_i = 2;
    @(negedge clk);
    #1 chk("dbg_abort_ack_before", dbg_ack_o, 1);
    rst = 1'b0;
    #1;
    chk("dbg_abort_ack", dbg_ack_o, 0);
    chk("dbg_abort_rdata", dbg_rdata_o, 0);
    dbg_req_i = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("dbg_abort_sp", rs1_data_o, 32'h2000);
    chk("dbg_abort_busy_cleared", rs1_busy_o, 0);
    @(negedge clk);
    #1 chk("dbg_abort_idle", dbg_ack_o, 0);
`else
    @(negedge clk);
    idle_inputs();
    dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 7; dbg_wdata_i = 32'h1234;
    rs1_addr_i = 7;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 2) dbg_we_i = 0;
      #1;
      chk($sformatf("nodbg%0d_ack", k), dbg_ack_o, 0);
      chk($sformatf("nodbg%0d_rdata", k), dbg_rdata_o, 0);
      chk($sformatf("nodbg%0d_x7", k), rs1_data_o, 32'hDEADBEEF);
    end
    dbg_req_i = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
